csa: RTL and testbench
======================

Name: csa

Overview:
- Parameterised carry-select adder: adds two WIDTH-bit unsigned operands plus a carry-in, giving a WIDTH-bit sum and a carry-out.
- Combinational carry-select core followed by one output register stage, clocked by a single clock with asynchronous active-low reset.
- Used as the arithmetic primitive in the stopwatch datapath (counter increment / digit arithmetic); built from full-adder (FA) cells.

Parameters:
- WIDTH, default 3, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- ci  input  1  carry-in.
- sum  output  WIDTH  registered low WIDTH bits of a+b+ci.
- co  output  1  registered carry-out (bit WIDTH of a+b+ci).

Behaviour:
- Function: {co,sum} = a + b + ci, computed exactly at WIDTH+1 bits. No overflow flag and no signed interpretation.
- Core structure, recursive carry-select:
  - Bit 0 is one FA(a[0], b[0], ci) producing sum0 and c1.
  - Bits WIDTH-1..1 are computed twice in parallel by a (WIDTH-1)-bit carry-select sub-adder: one copy with carry-in 0, one with carry-in 1.
  - c1 drives a 2:1 mux that selects that copy's sum bits and carry-out.
  - WIDTH=1 degenerates to a single FA.
- The core is purely combinational, with no latches. The ripple carry must not pass through the upper bits.
- Registers: sum and co capture the core result on every rising clk edge.
  - Latency is exactly 1 cycle: inputs stable before edge N appear on the outputs after edge N.
  - Throughput is one result per cycle; the block has no enable or handshake.
- Reset:
  - rst_n low clears sum to 0 and co to 0 immediately, without waiting for clk.
  - Outputs hold 0 while rst_n stays low.
  - The first capture happens on the first rising clk edge after rst_n deasserts.
  - Reset asserted mid-operation discards the pending result.
- Boundary conditions:
  - All-ones operands with ci=1 give sum all-ones and co=1.
  - a + b = 2^WIDTH - 1 with ci=1 gives wrap to 0 with co=1.
  - Zero operands with ci=0 give 0/0.
  - X on an input may propagate only to the affected outputs; no internal state persists beyond the output register.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with a=5, b=6 -> sum=0, co=0 immediately and held while low. Release rst_n -> the next edge gives sum=3, co=1.
- Exhaustive, WIDTH=3: sweep a=0..7, b=0..7, ci=0..1, one vector per cycle -> each result one cycle later equals {co,sum}=a+b+ci. Pass only if all 128 vectors match and the loop actually ran.
- Full carry chain: a=7, b=0, ci=1 -> sum=0, co=1. Then a=7, b=7, ci=1 -> sum=7, co=1.
- Back-to-back vectors: (1,2,0), (3,4,1), (0,0,0) on consecutive edges -> outputs 3/0, 0/1, 0/0 on consecutive cycles, with no bubbles.
- WIDTH=1 and WIDTH=8 instances: 1+1+1 gives sum=1, co=1. 255+1+0 gives sum=0, co=1. 100+27+1 gives sum=128, co=0.

Source files
------------

// File: rtl/csa.sv
// Carry-select adder with one output register stage: {co,sum} = a + b + ci.
// Upper bits are precomputed for both carry-in values; the lower carry only drives muxes.

module csa_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module csa #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  logic             s0;
  logic             c1;
  logic [WIDTH-1:0] sum_d;
  logic             co_d;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;

  csa_fa u_fa0 (
    .a_i(a[0]),
    .b_i(b[0]),
    .c_i(ci),
    .s_o(s0),
    .c_o(c1)
  );

  generate
    if (WIDTH == 1) begin : g_single
      assign sum_d = s0;
      assign co_d  = c1;
    end else begin : g_multi
      // Segment i holds bits i..WIDTH-1 for carry-in 0 and 1; it selects its own
      // upper half with its local carry, so no carry ever ripples across a segment.
      for (genvar i = WIDTH - 1; i >= 1; i--) begin : g_seg
        localparam int unsigned SW = WIDTH - i;
        logic [SW-1:0] sum_c0;
        logic [SW-1:0] sum_c1;
        logic          co_c0;
        logic          co_c1;
        logic          s_0;
        logic          cy_0;
        logic          s_1;
        logic          cy_1;

        csa_fa u_fa_c0 (
          .a_i(a[i]),
          .b_i(b[i]),
          .c_i(1'b0),
          .s_o(s_0),
          .c_o(cy_0)
        );

        csa_fa u_fa_c1 (
          .a_i(a[i]),
          .b_i(b[i]),
          .c_i(1'b1),
          .s_o(s_1),
          .c_o(cy_1)
        );

        if (i == WIDTH - 1) begin : g_top
          assign sum_c0 = s_0;
          assign sum_c1 = s_1;
          assign co_c0  = cy_0;
          assign co_c1  = cy_1;
        end else begin : g_mid
          assign sum_c0 = {(cy_0 ? g_seg[i+1].sum_c1 : g_seg[i+1].sum_c0), s_0};
          assign sum_c1 = {(cy_1 ? g_seg[i+1].sum_c1 : g_seg[i+1].sum_c0), s_1};
          assign co_c0  = cy_0 ? g_seg[i+1].co_c1 : g_seg[i+1].co_c0;
          assign co_c1  = cy_1 ? g_seg[i+1].co_c1 : g_seg[i+1].co_c0;
        end
      end

      assign sum_d = {(c1 ? g_seg[1].sum_c1 : g_seg[1].sum_c0), s0};
      assign co_d  = c1 ? g_seg[1].co_c1 : g_seg[1].co_c0;
    end
  endgenerate

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      co_q  <= co_d;
    end
  end

  assign sum = sum_q;
  assign co  = co_q;

endmodule

// File: tb/tb_csa.sv
// Scoreboard bench for csa at WIDTH 3, 1 and 8 driven in lockstep from one clock.
// Expected sums come from plain integer addition; a monitor pops one entry per edge.

module tb_csa;

  logic       clk;
  logic       rst_n;
  logic [2:0] a3, b3, sum3;
  logic       c3, co3;
  logic [0:0] a1, b1, sum1;
  logic       c1, co1;
  logic [7:0] a8, b8, sum8;
  logic       c8, co8;

  typedef struct {
    int e3;
    int e1;
    int e8;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   pushed = 0;
  int   popped = 0;

  csa #(.WIDTH(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .ci(c3), .sum(sum3), .co(co3)
  );
  csa #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(c1), .sum(sum1), .co(co1)
  );
  csa #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(c8), .sum(sum8), .co(co8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference: exact integer sum; low w bits are sum, bit w is carry-out.
  function automatic int low_bits(input int w, input int v);
    return v % (1 << w);
  endfunction

  function automatic int carry_bit(input int w, input int v);
    return v / (1 << w);
  endfunction

  // Drives all three adders and records their expected results; caller aligns to negedge.
  task automatic apply(input int x3, input int y3, input int z3,
                       input int x1, input int y1, input int z1,
                       input int x8, input int y8, input int z8);
    exp_t e;
    a3 = x3[2:0]; b3 = y3[2:0]; c3 = z3[0];
    a1 = x1[0:0]; b1 = y1[0:0]; c1 = z1[0];
    a8 = x8[7:0]; b8 = y8[7:0]; c8 = z8[0];
    e.e3 = x3 + y3 + z3;
    e.e1 = x1 + y1 + z1;
    e.e8 = x8 + y8 + z8;
    q.push_back(e);
    pushed++;
  endtask

  task automatic apply_rand_others(input int x3, input int y3, input int z3);
    apply(x3, y3, z3,
          int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)),
          int'($urandom_range(255)), int'($urandom_range(255)), int'($urandom_range(1)));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        popped++;
        check("w3_sum", 32'(sum3), 32'(low_bits(3, e.e3)));
        check("w3_co",  32'(co3),  32'(carry_bit(3, e.e3)));
        check("w1_sum", 32'(sum1), 32'(low_bits(1, e.e1)));
        check("w1_co",  32'(co1),  32'(carry_bit(1, e.e1)));
        check("w8_sum", 32'(sum8), 32'(low_bits(8, e.e8)));
        check("w8_co",  32'(co8),  32'(carry_bit(8, e.e8)));
      end
    end
  end

  initial begin : stimulus
    a3 = '0; b3 = '0; c3 = 1'b0;
    a1 = '0; b1 = '0; c1 = 1'b0;
    a8 = '0; b8 = '0; c8 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_w3_sum", 32'(sum3), 0);
    check("rst_w3_co",  32'(co3),  0);
    check("rst_w8_sum", 32'(sum8), 0);
    check("rst_w1_co",  32'(co1),  0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: zeros, full carry chain, and the wide-instance boundary cases.
    apply(0, 0, 0, 1, 1, 1, 255, 1, 0);
    @(negedge clk); apply(7, 0, 1, 0, 0, 0, 100, 27, 1);
    @(negedge clk); apply(7, 7, 1, 1, 1, 1, 255, 255, 1);
    // Back-to-back with no bubbles.
    @(negedge clk); apply(1, 2, 0, 1, 0, 0, 128, 127, 0);
    @(negedge clk); apply(3, 4, 1, 0, 1, 1, 0, 0, 0);
    @(negedge clk); apply(0, 0, 0, 0, 0, 0, 200, 100, 1);

    // Exhaustive sweep of the 3-bit instance.
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int z = 0; z < 2; z++) begin
          @(negedge clk);
          apply_rand_others(x, y, z);
        end

    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      apply_rand_others(int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(1)));
    end

    // Leave the outputs nonzero, then assert reset mid-cycle with a pending 5+6.
    @(negedge clk); apply(7, 7, 1, 1, 1, 1, 255, 255, 1);
    @(posedge clk);
    #3;
    a3 = 3'd5; b3 = 3'd6; c3 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum", 32'(sum3), 0);
    check("async_rst_co",  32'(co3),  0);
    check("async_rst_w8",  32'(sum8), 0);
    repeat (2) @(posedge clk);
    #1;
    check("held_rst_sum", 32'(sum3), 0);
    check("held_rst_co",  32'(co3),  0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(5, 6, 0, 1, 1, 1, 255, 1, 0);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 0);
    check("all_results_seen", 32'(popped), 32'(pushed));
    check("exhaustive_ran", 32'(popped >= 128 + 6), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
